// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer.
// The entry layout is fixed here, so every consumer agrees on which bits hold the PC
// and which hold the instruction word.
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // One buffered fetch: the PC and the instruction word read at that PC.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Builds an entry from the fetch-stage inputs.
  function automatic fetch_entry_t make_entry(input logic [ADDR_W-1:0]  pc,
                                              input logic [INSTR_W-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer_wrap_ctr.sv
// wrap_ctr: W-bit register with synchronous reset, synchronous clear and increment.
// The value wraps from 2**W-1 back to 0 through ordinary modular arithmetic.
// Clear takes priority over increment.
module wrap_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next value: clear wins, otherwise step by one when asked.
  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (inc) begin
      val_d = val_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO between the fetch stage and decode.
//
// Optional feature: define FETCH_BUFFER_STATS_EN to add the saturating stall_cnt and
// flush_cnt outputs. Without the macro those ports and counters do not exist.
//
// Handshake (both sides): a transfer happens in a cycle where valid and ready are both
// high at the rising edge. valid may be held without waiting for ready; ready is derived
// from registered state only, so neither output depends combinationally on any input.
// A taken branch (flush_F) cancels both transfers in its cycle and empties the buffer.
//
// The PC is stored in an ADDR_W-bit field; N must not exceed ADDR_W.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int N     = ADDR_W,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       imem_addr_F,
  input  logic [INSTR_W-1:0] instr_F,
  input  logic               valid_F,
  output logic               ready_F,
  input  logic               flush_F,
  output logic [N-1:0]       pc_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic               valid_D,
  input  logic               ready_D
`ifdef FETCH_BUFFER_STATS_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;
  fetch_entry_t     head;

  // Status is decoded from the registered count only: no pass-through when full,
  // no bypass when empty.
  assign ready_F = (count_q != FULL_CNT);
  assign valid_D = (count_q != '0);
  assign push    = valid_F & ready_F & ~flush_F;
  assign pop     = valid_D & ready_D & ~flush_F;

  // Head entry drives decode directly from storage.
  assign head    = mem_q[rd_ptr];
  assign pc_D    = N'(head.pc);
  assign instr_D = head.instr;

  // Read and write pointers; a flush returns both to slot 0.
  wrap_ctr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_F),
    .inc   (pop),
    .val   (rd_ptr)
  );

  wrap_ctr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_F),
    .inc   (push),
    .val   (wr_ptr)
  );

  // Storage update: write the incoming pair at the tail on an accepted push.
  // Flush leaves storage untouched; only the pointers and count are cleared.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr] = make_entry(ADDR_W'(imem_addr_F), instr_F);
    end
  end

  // Occupancy: flush empties, otherwise push and pop each move it by one.
  always_comb begin
    count_d = count_q;
    if (flush_F) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and count registers; reset zeroes everything so pc_D/instr_D read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

`ifdef FETCH_BUFFER_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Saturating event counters: fetch held off by a full buffer, and flushes that
  // actually discarded at least one entry.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_F && !ready_F && !flush_F && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush_F && (count_q != '0) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer (DEPTH=2, N=64).
// Define FETCH_BUFFER_STATS_EN when compiling to also exercise the stats counters.
module tb_fetch_buffer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr_F;
  logic [31:0] instr_F;
  logic        valid_F;
  logic        ready_F;
  logic        flush_F;
  logic [63:0] pc_D;
  logic [31:0] instr_D;
  logic        valid_D;
  logic        ready_D;
`ifdef FETCH_BUFFER_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_buffer #(.N(64), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr_F (imem_addr_F),
    .instr_F     (instr_F),
    .valid_F     (valid_F),
    .ready_F     (ready_F),
    .flush_F     (flush_F),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .ready_D     (ready_D)
`ifdef FETCH_BUFFER_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        vf;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        fl;
    logic        rd;
    logic        e_rf;
    logic        e_vd;
    logic        chk_data;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  logic [63:0] exp_q[$];

  task automatic add_vec(input logic rst, input logic vf, input logic [63:0] pc,
                         input logic [31:0] ins, input logic fl, input logic rd,
                         input logic e_rf, input logic e_vd, input logic chk_data,
                         input logic [63:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.rst = rst; v.vf = vf; v.pc = pc; v.ins = ins; v.fl = fl; v.rd = rd;
    v.e_rf = e_rf; v.e_vd = e_vd; v.chk_data = chk_data; v.e_pc = e_pc; v.e_ins = e_ins;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  // Waits for the falling edge, then drives this cycle's inputs.
  task automatic drive(input logic rst, input logic vf, input logic [63:0] pc,
                       input logic [31:0] ins, input logic fl, input logic rd);
    @(negedge clk);
    reset       = rst;
    valid_F     = vf;
    imem_addr_F = pc;
    instr_F     = ins;
    flush_F     = fl;
    ready_D     = rd;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic e_rf, input logic e_vd,
                             input logic chk_data, input logic [63:0] e_pc,
                             input logic [31:0] e_ins);
    check({tag, ".ready_F"}, 64'(ready_F), 64'(e_rf));
    check({tag, ".valid_D"}, 64'(valid_D), 64'(e_vd));
    if (chk_data) begin
      check({tag, ".pc_D"},    pc_D,           e_pc);
      check({tag, ".instr_D"}, 64'(instr_D),   64'(e_ins));
    end
  endtask

  initial begin
    // Reset held across the first edge (and the first vector's edge).
    reset = 1'b1; valid_F = 1'b1; imem_addr_F = 64'h100; instr_F = 32'hDEAD_BEEF;
    flush_F = 1'b0; ready_D = 1'b0;

    // rst vf  pc      ins            fl rd   rf vd chk pc      ins
    // Reset with valid_F=1, then idle: reset state throughout.
    add_vec(1, 1, 64'h100, 32'hDEADBEEF, 0, 0,  1, 0, 1, 64'h0,  32'h0);
    add_vec(0, 0, 64'h0,   32'h0,        0, 0,  1, 0, 1, 64'h0,  32'h0);
    // Fill then drain.
    add_vec(0, 1, 64'h0,   32'h8B020020, 0, 0,  1, 0, 1, 64'h0,  32'h0);
    add_vec(0, 1, 64'h4,   32'hCB020020, 0, 0,  1, 1, 1, 64'h0,  32'h8B020020);
    add_vec(0, 1, 64'h8,   32'h00000011, 0, 0,  0, 1, 1, 64'h0,  32'h8B020020);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  0, 1, 1, 64'h0,  32'h8B020020);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  1, 1, 1, 64'h4,  32'hCB020020);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  1, 0, 0, 64'h0,  32'h0);
    // Full + pop: pop only, then push accepted next cycle.
    add_vec(0, 1, 64'h10,  32'h000000A0, 0, 0,  1, 0, 0, 64'h0,  32'h0);
    add_vec(0, 1, 64'h14,  32'h000000A1, 0, 0,  1, 1, 1, 64'h10, 32'hA0);
    add_vec(0, 1, 64'h18,  32'h000000A2, 0, 1,  0, 1, 1, 64'h10, 32'hA0);
    add_vec(0, 1, 64'h18,  32'h000000A2, 0, 0,  1, 1, 1, 64'h14, 32'hA1);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  0, 1, 1, 64'h14, 32'hA1);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  1, 1, 1, 64'h18, 32'hA2);
    add_vec(0, 0, 64'h0,   32'h0,        0, 0,  1, 0, 0, 64'h0,  32'h0);
    // Flush with one entry held and a push of 0x40 in the same cycle.
    add_vec(0, 1, 64'h30,  32'h000000B0, 0, 0,  1, 0, 0, 64'h0,  32'h0);
    add_vec(0, 1, 64'h40,  32'h000000B1, 1, 1,  1, 1, 1, 64'h30, 32'hB0);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  1, 0, 0, 64'h0,  32'h0);
    add_vec(0, 1, 64'h44,  32'h000000B2, 0, 0,  1, 0, 0, 64'h0,  32'h0);
    add_vec(0, 0, 64'h0,   32'h0,        0, 1,  1, 1, 1, 64'h44, 32'hB2);
    add_vec(0, 0, 64'h0,   32'h0,        0, 0,  1, 0, 0, 64'h0,  32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vf, vecs[i].pc, vecs[i].ins, vecs[i].fl, vecs[i].rd);
      check_state($sformatf("vec%0d", i), vecs[i].e_rf, vecs[i].e_vd, vecs[i].chk_data,
                  vecs[i].e_pc, vecs[i].e_ins);
    end

    // Continuous streaming with ready_D=1: each PC appears one cycle after its push,
    // in order, across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i < 7), 64'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b1);
      check($sformatf("wrap%0d.ready_F", i), 64'(ready_F), 64'd1);
      check($sformatf("wrap%0d.valid_D", i), 64'(valid_D), 64'(i != 0));
      if (i != 0) begin
        check($sformatf("wrap%0d.pc_D", i), pc_D, exp_q.pop_front());
        check($sformatf("wrap%0d.instr_D", i), 64'(instr_D), 64'(32'h1000 + 32'(i - 1)));
      end
      if (i < 7) exp_q.push_back(64'(4 * i));
    end
    check("wrap.queue_left", 64'(exp_q.size()), 64'd0);
    drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
    check_state("wrap_end", 1'b1, 1'b0, 1'b0, 64'h0, 32'h0);

    // Reset mid-operation (with flush and push asserted) restores the reset state,
    // including zeroed storage.
    drive(1'b0, 1'b1, 64'h50, 32'h000000C0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'h54, 32'h000000C1, 1'b0, 1'b0);
    check_state("pre_rst", 1'b1, 1'b1, 1'b1, 64'h50, 32'hC0);
    drive(1'b1, 1'b1, 64'h58, 32'h000000C2, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check_state("mid_rst", 1'b1, 1'b0, 1'b1, 64'h0, 32'h0);

`ifdef FETCH_BUFFER_STATS_EN
    check("stats_rst.stall_cnt", 64'(stall_cnt), 64'd0);
    check("stats_rst.flush_cnt", 64'(flush_cnt), 64'd0);
    drive(1'b0, 1'b1, 64'h60, 32'h000000D0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'h64, 32'h000000D1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 64'h68, 32'h000000D2, 1'b0, 1'b0);
    end
    // Flush with fetch still presenting: counts as a flush, not a stall.
    drive(1'b0, 1'b1, 64'h68, 32'h000000D2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("stats.stall_cnt", 64'(stall_cnt), 64'd3);
    check("stats.flush_cnt", 64'(flush_cnt), 64'd1);
    drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check("stats_empty_flush.flush_cnt", 64'(flush_cnt), 64'd1);
    drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check("stats_rst2.stall_cnt", 64'(stall_cnt), 64'd0);
    check("stats_rst2.flush_cnt", 64'(flush_cnt), 64'd0);
`endif

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
